register_txd: RTL and testbench

Frame transmitter for the two-player UART link. Snapshots the local game state on a send request, serialises it as one 14-byte frame (4-byte 0xFF preamble, then 10 payload bytes), and hands bytes one at a time to the UART transmitter. It sits between the game-logic registers and the UART TX core. Its frame format is exactly what the peer board's frame receiver parses.

---
 rtl/uart_frame_pkg.sv | 65 ++++++
 rtl/register_txd.sv | 159 +++++++++++++++
 tb/tb_register_txd.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Frame layout shared by the register transmitter and the peer frame receiver.
// Sync preamble, then payload bytes little-endian with a trailing flags byte.
package uart_frame_pkg;

  localparam int unsigned PREAMBLE_LEN  = 4;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'hFF;
  localparam int unsigned PAYLOAD_BYTES = 10;
  localparam int unsigned FRAME_BYTES   = PREAMBLE_LEN + PAYLOAD_BYTES;

  // Payload-relative byte offsets
  localparam logic [3:0] PL_X_LO  = 4'd0;
  localparam logic [3:0] PL_X_HI  = 4'd1;
  localparam logic [3:0] PL_Y_LO  = 4'd2;
  localparam logic [3:0] PL_Y_HI  = 4'd3;
  localparam logic [3:0] PL_XB_LO = 4'd4;
  localparam logic [3:0] PL_XB_HI = 4'd5;
  localparam logic [3:0] PL_YB_LO = 4'd6;
  localparam logic [3:0] PL_YB_HI = 4'd7;
  localparam logic [3:0] PL_HP    = 4'd8;
  localparam logic [3:0] PL_FLAGS = 4'd9;

  // Absolute frame indices
  localparam logic [3:0] IDX_X_LO  = 4'(PREAMBLE_LEN) + PL_X_LO;
  localparam logic [3:0] IDX_X_HI  = 4'(PREAMBLE_LEN) + PL_X_HI;
  localparam logic [3:0] IDX_Y_LO  = 4'(PREAMBLE_LEN) + PL_Y_LO;
  localparam logic [3:0] IDX_Y_HI  = 4'(PREAMBLE_LEN) + PL_Y_HI;
  localparam logic [3:0] IDX_XB_LO = 4'(PREAMBLE_LEN) + PL_XB_LO;
  localparam logic [3:0] IDX_XB_HI = 4'(PREAMBLE_LEN) + PL_XB_HI;
  localparam logic [3:0] IDX_YB_LO = 4'(PREAMBLE_LEN) + PL_YB_LO;
  localparam logic [3:0] IDX_YB_HI = 4'(PREAMBLE_LEN) + PL_YB_HI;
  localparam logic [3:0] IDX_HP    = 4'(PREAMBLE_LEN) + PL_HP;
  localparam logic [3:0] IDX_FLAGS = 4'(PREAMBLE_LEN) + PL_FLAGS;

  // Flags byte bit positions
  localparam int unsigned TANK_HIT      = 0;
  localparam int unsigned DIR_ENEMY_LSB = 1;
  localparam int unsigned DIR_ENEMY_MSB = 3;
  localparam int unsigned DIR_TANK_LSB  = 4;
  localparam int unsigned DIR_TANK_MSB  = 5;
  localparam int unsigned OBST_HIT      = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } txd_state_e;

  function automatic logic [7:0] pack_flags(
    input logic       tank_hit,
    input logic [2:0] dir_enemy,
    input logic [1:0] dir_tank,
    input logic       obst_hit
  );
    logic [7:0] f;
    f = 8'h00;
    f[TANK_HIT] = tank_hit;
    f[DIR_ENEMY_MSB:DIR_ENEMY_LSB] = dir_enemy;
    f[DIR_TANK_MSB:DIR_TANK_LSB] = dir_tank;
    f[OBST_HIT] = obst_hit;
    return f;
  endfunction

endpackage

// File: rtl/register_txd.sv
// Frame transmitter: snapshots local game state and feeds one
// preamble-led frame byte by byte into the UART TX core.
module register_txd #(
  parameter int unsigned PREAMBLE_LEN  = uart_frame_pkg::PREAMBLE_LEN,
  parameter logic [7:0]  PREAMBLE_BYTE = uart_frame_pkg::PREAMBLE_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_req,
  input  logic [15:0] X_tank_pos,
  input  logic [15:0] Y_tank_pos,
  input  logic [9:0]  xpos_bullet,
  input  logic [9:0]  ypos_bullet,
  input  logic [7:0]  HP_state,
  input  logic [2:0]  direction_for_enemy,
  input  logic        tank_hit,
  input  logic [1:0]  direction_tank,
  input  logic        obstacle_hit,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_sent
);
  import uart_frame_pkg::*;

  localparam logic [3:0] PRE_LEN  = 4'(PREAMBLE_LEN);
  localparam logic [3:0] LAST_IDX =
    4'(PREAMBLE_LEN + PAYLOAD_BYTES - 1);

  txd_state_e  state_q;
  logic [3:0]  idx_q;
  logic        pend_q;

  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [9:0]  xb_q;
  logic [9:0]  yb_q;
  logic [7:0]  hp_q;
  logic [7:0]  flags_q;

  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        busy_q;
  logic        frame_sent_q;

  logic [3:0]  idx_d;
  logic [3:0]  pl;
  logic [7:0]  byte_d;

  // Index of the byte about to be issued: 0 from LOAD, +1 from WAIT
  assign idx_d = (state_q == ST_WAIT) ? idx_q + 4'd1 : 4'd0;
  assign pl    = idx_d - PRE_LEN;

  always_comb begin
    byte_d = PREAMBLE_BYTE;
    if (idx_d >= PRE_LEN) begin
      case (pl)
        PL_X_LO:  byte_d = x_q[7:0];
        PL_X_HI:  byte_d = x_q[15:8];
        PL_Y_LO:  byte_d = y_q[7:0];
        PL_Y_HI:  byte_d = y_q[15:8];
        PL_XB_LO: byte_d = xb_q[7:0];
        PL_XB_HI: byte_d = {6'b0, xb_q[9:8]};
        PL_YB_LO: byte_d = yb_q[7:0];
        PL_YB_HI: byte_d = {6'b0, yb_q[9:8]};
        PL_HP:    byte_d = hp_q;
        PL_FLAGS: byte_d = flags_q;
        default:  byte_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      pend_q       <= 1'b0;
      x_q          <= 16'h0000;
      y_q          <= 16'h0000;
      xb_q         <= 10'h000;
      yb_q         <= 10'h000;
      hp_q         <= 8'h00;
      flags_q      <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_sent_q <= 1'b0;
      if (send_req && state_q != ST_IDLE) begin
        pend_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (send_req || pend_q) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
            x_q     <= X_tank_pos;
            y_q     <= Y_tank_pos;
            xb_q    <= xpos_bullet;
            yb_q    <= ypos_bullet;
            hp_q    <= HP_state;
            flags_q <= pack_flags(tank_hit,
                                  direction_for_enemy,
                                  direction_tank,
                                  obstacle_hit);
          end
        end
        ST_LOAD: begin
          idx_q      <= idx_d;
          state_q    <= ST_ISSUE;
          tx_start_q <= 1'b1;
          tx_data_q  <= byte_d;
        end
        ST_ISSUE: begin
          if (idx_q > LAST_IDX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (idx_q > LAST_IDX) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tx_done) begin
            if (idx_q == LAST_IDX) begin
              state_q      <= ST_DONE;
              frame_sent_q <= 1'b1;
            end else begin
              idx_q      <= idx_d;
              state_q    <= ST_ISSUE;
              tx_start_q <= 1'b1;
              tx_data_q  <= byte_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_sent = frame_sent_q;

endmodule

// File: tb/tb_register_txd.sv
// Bench for register_txd: scoreboarded bytes against a UART TX model
// that answers each tx_start with tx_done ten cycles later.
module tb_register_txd;
  import uart_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send_req = 1'b0;
  logic [15:0] x = '0;
  logic [15:0] y = '0;
  logic [9:0]  xb = '0;
  logic [9:0]  yb = '0;
  logic [7:0]  hp = '0;
  logic [2:0]  de = '0;
  logic        hit = 1'b0;
  logic [1:0]  dt = '0;
  logic        obst = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_sent;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];
  logic [7:0] rx[$];
  int tx_cnt = 0;
  int frm_cnt = 0;
  int cnt = 0;
  bit spur_issue = 1'b0;
  bit inj_idle = 1'b0;

  always #5 clk = ~clk;

  register_txd dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .send_req            (send_req),
    .X_tank_pos          (x),
    .Y_tank_pos          (y),
    .xpos_bullet         (xb),
    .ypos_bullet         (yb),
    .HP_state            (hp),
    .direction_for_enemy (de),
    .tank_hit            (hit),
    .direction_tank      (dt),
    .obstacle_hit        (obst),
    .tx_done             (tx_done),
    .tx_start            (tx_start),
    .tx_data             (tx_data),
    .busy                (busy),
    .frame_sent          (frame_sent)
  );

  // UART TX model and byte scoreboard
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      tx_done = inj_idle;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
      if (frame_sent) frm_cnt++;
      if (tx_start) begin
        tx_cnt++;
        rx.push_back(tx_data);
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_byte got=%h want=none", tx_data);
        end else begin
          exp = sb.pop_front();
          if (tx_data !== exp) begin
            failures++;
            $display("FAIL byte got=%h want=%h", tx_data, exp);
          end
        end
        cnt = 10;
        if (spur_issue) tx_done = 1'b1;
      end
    end
  end

  task automatic push_frame();
    for (int i = 0; i < 4; i++) sb.push_back(8'hFF);
    sb.push_back(x[7:0]);
    sb.push_back(x[15:8]);
    sb.push_back(y[7:0]);
    sb.push_back(y[15:8]);
    sb.push_back(xb[7:0]);
    sb.push_back({6'b0, xb[9:8]});
    sb.push_back(yb[7:0]);
    sb.push_back({6'b0, yb[9:8]});
    sb.push_back(hp);
    sb.push_back({1'b0, obst, dt, de, hit});
  endtask

  task automatic pulse_req(input bit expect_frame);
    @(negedge clk);
    send_req = 1'b1;
    if (expect_frame) push_frame();
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frm_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (frm_cnt < target) begin
      failures++;
      $display("FAIL frame_timeout got=%0d want=%0d", frm_cnt, target);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 ||
        busy !== 1'b0 || frame_sent !== 1'b0) begin
      failures++;
      $display("FAIL %s got=%b/%h/%b/%b want=0/00/0/0", tag,
               tx_start, tx_data, busy, frame_sent);
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_reset_idle");
  endtask

  task automatic test_basic();
    int n;
    int f0;
    int t0;
    x = 16'h1234; y = 16'h0056; xb = 10'h3FF; yb = 10'h001;
    hp = 8'd100; de = 3'b101; hit = 1'b1; dt = 2'b10; obst = 1'b1;
    f0 = frm_cnt;
    t0 = tx_cnt;
    rx.delete();
    @(negedge clk);
    send_req = 1'b1;
    push_frame();
    @(negedge clk);
    send_req = 1'b0;
    n = 1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got=%b want=1", busy);
    end
    while (!frame_sent && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 156) begin
      failures++;
      $display("FAIL frame_len got=%0d want=156", n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_sent !== 1'b0) begin
      failures++;
      $display("FAIL busy_fall got=%b/%b want=0/0", busy, frame_sent);
    end
    checks++;
    if (frm_cnt - f0 != 1 || tx_cnt - t0 != 14 || sb.size() != 0) begin
      failures++;
      $display("FAIL basic_counts got=%0d/%0d/%0d want=1/14/0",
               frm_cnt - f0, tx_cnt - t0, sb.size());
    end
    // Peer-receiver style decode of the captured frame
    if (rx.size() >= 14) begin
      logic [7:0] fl;
      fl = rx[13];
      checks++;
      if ({rx[5], rx[4]} !== x || {rx[7], rx[6]} !== y) begin
        failures++;
        $display("FAIL rx_pos got=%h%h/%h%h want=%h/%h",
                 rx[5], rx[4], rx[7], rx[6], x, y);
      end
      checks++;
      if ({rx[9][1:0], rx[8]} !== xb || {rx[11][1:0], rx[10]} !== yb ||
          rx[12] !== hp) begin
        failures++;
        $display("FAIL rx_bullet_hp got=%h/%h/%h want=%h/%h/%h",
                 {rx[9][1:0], rx[8]}, {rx[11][1:0], rx[10]}, rx[12],
                 xb, yb, hp);
      end
      checks++;
      if (fl[TANK_HIT] !== hit ||
          fl[DIR_ENEMY_MSB:DIR_ENEMY_LSB] !== de ||
          fl[DIR_TANK_MSB:DIR_TANK_LSB] !== dt ||
          fl[OBST_HIT] !== obst) begin
        failures++;
        $display("FAIL rx_flags got=%h want=hit%b de%b dt%b ob%b",
                 fl, hit, de, dt, obst);
      end
    end else begin
      checks++;
      failures++;
      $display("FAIL rx_size got=%0d want=14", rx.size());
    end
  endtask

  task automatic test_midframe_change();
    int k;
    int t0;
    int f0;
    x = 16'hA5C3; y = 16'hFFFF; xb = 10'h155; yb = 10'h2AA;
    hp = 8'hFF; de = 3'b011; hit = 1'b0; dt = 2'b01; obst = 1'b0;
    t0 = tx_cnt;
    f0 = frm_cnt;
    pulse_req(1'b1);
    k = 0;
    while (tx_cnt - t0 < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    x = $urandom; y = $urandom; xb = $urandom; yb = $urandom;
    hp = $urandom; de = $urandom; hit = ~hit; dt = ~dt; obst = ~obst;
    wait_frames(f0 + 1, 400);
    checks++;
    if (sb.size() != 0 || tx_cnt - t0 != 14) begin
      failures++;
      $display("FAIL midframe got=%0d/%0d want=0/14",
               sb.size(), tx_cnt - t0);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int f0;
    x = 16'h0F0F; y = 16'h7001; xb = 10'h200; yb = 10'h0FF;
    hp = 8'd3; de = 3'b110; hit = 1'b1; dt = 2'b11; obst = 1'b0;
    t0 = tx_cnt;
    f0 = frm_cnt;
    pulse_req(1'b1);
    repeat (20) @(negedge clk);
    pulse_req(1'b1);
    repeat (20) @(negedge clk);
    pulse_req(1'b0);
    wait_frames(f0 + 2, 800);
    repeat (60) @(negedge clk);
    checks++;
    if (frm_cnt - f0 != 2 || tx_cnt - t0 != 28 || sb.size() != 0) begin
      failures++;
      $display("FAIL back_to_back got=%0d/%0d/%0d want=2/28/0",
               frm_cnt - f0, tx_cnt - t0, sb.size());
    end
  endtask

  task automatic test_spurious_done();
    int t0;
    int f0;
    t0 = tx_cnt;
    f0 = frm_cnt;
    inj_idle = 1'b1;
    repeat (5) @(negedge clk);
    inj_idle = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_cnt != t0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_done got=%0d/%b want=%0d/0", tx_cnt, busy, t0);
    end
    x = 16'h8001; y = 16'h00FF; xb = 10'h0FF; yb = 10'h3FE;
    hp = 8'h80; de = 3'b001; hit = 1'b0; dt = 2'b00; obst = 1'b1;
    spur_issue = 1'b1;
    pulse_req(1'b1);
    wait_frames(f0 + 1, 400);
    spur_issue = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_cnt - t0 != 14 || sb.size() != 0) begin
      failures++;
      $display("FAIL issue_done got=%0d/%0d want=14/0",
               tx_cnt - t0, sb.size());
    end
  endtask

  task automatic test_reset_midframe();
    int k;
    int t0;
    int t1;
    int f0;
    x = 16'h4321; y = 16'h1357; xb = 10'h011; yb = 10'h022;
    hp = 8'd50; de = 3'b010; hit = 1'b1; dt = 2'b01; obst = 1'b1;
    t0 = tx_cnt;
    pulse_req(1'b1);
    k = 0;
    while (tx_cnt - t0 < 8 && k < 300) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_midframe");
    sb.delete();
    cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (tx_cnt - t0 != 8 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop got=%0d/%b want=8/0", tx_cnt - t0, busy);
    end
    t1 = tx_cnt;
    f0 = frm_cnt;
    rx.delete();
    pulse_req(1'b1);
    wait_frames(f0 + 1, 400);
    checks++;
    if (rx.size() != 14 || tx_cnt - t1 != 14 || sb.size() != 0) begin
      failures++;
      $display("FAIL restart got=%0d/%0d/%0d want=14/14/0",
               rx.size(), tx_cnt - t1, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_change();
    test_back_to_back();
    test_spurious_done();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
